boson_cmos_tx: RTL

Parallel CMOS video transmitter emulating the Boson camera's 16-bit pixel output. Generates pixel clock, VALID, HSYNC, VSYNC and data from either a 32-bit word stream (two pixels per word, FWFT FIFO-style source) or an internal ramp pattern. Drives the capture path in loopback and bench setups, and drives the camera-side pins in the emulator build. Packing matches the capture side: word[31:16] is the earlier pixel.

---
 rtl/boson_cmos_pkg.sv | 22 ++
 rtl/video_timing_gen.sv | 64 ++++++
 rtl/boson_cmos_tx.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/boson_cmos_pkg.sv
// Shared types and default Boson timing for the CMOS video transmitter.
// Timing values are in pixel ticks (horizontal) or lines (vertical).
package boson_cmos_pkg;

  localparam int H_W = 12;
  localparam int V_W = 11;

  localparam int DEF_H_TOTAL     = 800;
  localparam int DEF_H_ACTIVE    = 640;
  localparam int DEF_H_START     = 32;
  localparam int DEF_HSYNC_TICKS = 16;
  localparam int DEF_V_TOTAL     = 526;
  localparam int DEF_V_ACTIVE    = 512;
  localparam int DEF_V_START     = 4;
  localparam int DEF_VSYNC_LINES = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/video_timing_gen.sv
// Horizontal/vertical pixel-tick counters with sync, active and end-of-frame flags.
// Counters are held at zero while i_clr and step once per i_adv.
module video_timing_gen
  import boson_cmos_pkg::*;
#(
  parameter int H_TOTAL     = DEF_H_TOTAL,
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_START     = DEF_H_START,
  parameter int HSYNC_TICKS = DEF_HSYNC_TICKS,
  parameter int V_TOTAL     = DEF_V_TOTAL,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_START     = DEF_V_START,
  parameter int VSYNC_LINES = DEF_VSYNC_LINES
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_clr,
  input  logic           i_adv,
  output logic           o_hsync,
  output logic           o_vsync,
  output logic           o_active,
  output logic [H_W-1:0] o_x,
  output logic [V_W-1:0] o_y,
  output logic           o_eof
);

  logic [H_W-1:0] r_h;
  logic [V_W-1:0] r_v;
  logic           w_h_end;
  logic           w_v_end;
  logic           w_h_act;
  logic           w_v_act;

  assign w_h_end = (r_h == H_W'(H_TOTAL - 1));
  assign w_v_end = (r_v == V_W'(V_TOTAL - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (i_clr) begin
      r_h <= '0;
      r_v <= '0;
    end else if (i_adv) begin
      if (w_h_end) begin
        r_h <= '0;
        r_v <= w_v_end ? '0 : r_v + V_W'(1);
      end else begin
        r_h <= r_h + H_W'(1);
      end
    end
  end

  assign w_h_act  = (r_h >= H_W'(H_START)) && (r_h < H_W'(H_START + H_ACTIVE));
  assign w_v_act  = (r_v >= V_W'(V_START)) && (r_v < V_W'(V_START + V_ACTIVE));

  assign o_hsync  = (r_h >= H_W'(HSYNC_TICKS));
  assign o_vsync  = (r_v >= V_W'(VSYNC_LINES));
  assign o_active = w_h_act && w_v_act;
  assign o_x      = r_h - H_W'(H_START);
  assign o_y      = r_v - V_W'(V_START);
  assign o_eof    = w_h_end && w_v_end;

endmodule

// File: rtl/boson_cmos_tx.sv
// Boson-style 16-bit parallel CMOS transmitter: pixel clock, syncs and data from a
// two-pixel-per-word stream or an internal (x+y) ramp.
module boson_cmos_tx
  import boson_cmos_pkg::*;
#(
  parameter int H_TOTAL     = DEF_H_TOTAL,
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_START     = DEF_H_START,
  parameter int HSYNC_TICKS = DEF_HSYNC_TICKS,
  parameter int V_TOTAL     = DEF_V_TOTAL,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_START     = DEF_V_START,
  parameter int VSYNC_LINES = DEF_VSYNC_LINES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        pattern_en,
  input  logic [31:0] input_d,
  input  logic        input_rdy,
  output logic        input_next,
  output logic        underrun,
  input  logic        underrun_clr,
  output logic        frame_done,
  output logic        CAM_CMOS_CLK,
  output logic [15:0] CAM_CMOS_D,
  output logic        CAM_CMOS_VALID,
  output logic        CAM_CMOS_HSYNC,
  output logic        CAM_CMOS_VSYNC
);

  state_t         r_state;
  state_t         w_next;
  logic           r_ph;
  logic           r_pat;
  logic           r_skip;
  logic [15:0]    r_lo;
  logic           w_tick;
  logic           w_hsync;
  logic           w_vsync;
  logic           w_active;
  logic [H_W-1:0] w_x;
  logic [V_W-1:0] w_y;
  logic           w_eof;
  logic [15:0]    w_d;
  logic           w_pop;
  logic           w_ur_set;

  // A pixel tick ends on the edge where the pixel clock falls.
  assign w_tick       = (r_state == ST_RUN) && r_ph;
  assign CAM_CMOS_CLK = r_ph;

  video_timing_gen #(
    .H_TOTAL    (H_TOTAL),
    .H_ACTIVE   (H_ACTIVE),
    .H_START    (H_START),
    .HSYNC_TICKS(HSYNC_TICKS),
    .V_TOTAL    (V_TOTAL),
    .V_ACTIVE   (V_ACTIVE),
    .V_START    (V_START),
    .VSYNC_LINES(VSYNC_LINES)
  ) u_timing (
    .clk     (clk),
    .rst     (reset),
    .i_clr   (r_state == ST_IDLE),
    .i_adv   (w_tick),
    .o_hsync (w_hsync),
    .o_vsync (w_vsync),
    .o_active(w_active),
    .o_x     (w_x),
    .o_y     (w_y),
    .o_eof   (w_eof)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (enable) w_next = ST_RUN;
      ST_RUN:  if (w_tick && w_eof && !enable) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_d      = '0;
    w_pop    = 1'b0;
    w_ur_set = 1'b0;
    if (w_active) begin
      if (r_pat) begin
        w_d = 16'(w_x) + 16'(w_y);
      end else if (!w_x[0]) begin
        if (input_rdy) begin
          w_d   = input_d[31:16];
          w_pop = 1'b1;
        end else begin
          w_ur_set = 1'b1;
        end
      end else if (!r_skip) begin
        w_d = r_lo;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_ph           <= 1'b0;
      r_pat          <= 1'b0;
      r_skip         <= 1'b0;
      r_lo           <= '0;
      input_next     <= 1'b0;
      frame_done     <= 1'b0;
      CAM_CMOS_D     <= '0;
      CAM_CMOS_VALID <= 1'b0;
      CAM_CMOS_HSYNC <= 1'b1;
      CAM_CMOS_VSYNC <= 1'b1;
    end else begin
      r_state    <= w_next;
      r_ph       <= (w_next == ST_RUN) ? ~r_ph : 1'b0;
      input_next <= w_tick && w_pop;
      frame_done <= w_tick && w_eof;
      if (w_tick) begin
        CAM_CMOS_D     <= w_d;
        CAM_CMOS_VALID <= w_active;
        CAM_CMOS_HSYNC <= w_hsync;
        CAM_CMOS_VSYNC <= w_vsync;
        if (w_active && !r_pat && !w_x[0]) begin
          r_skip <= !input_rdy;
          if (input_rdy) r_lo <= input_d[15:0];
        end
        if (w_eof) r_pat <= pattern_en;
      end else if (r_state == ST_IDLE) begin
        CAM_CMOS_D     <= '0;
        CAM_CMOS_VALID <= 1'b0;
        CAM_CMOS_HSYNC <= 1'b1;
        CAM_CMOS_VSYNC <= 1'b1;
        if (enable) r_pat <= pattern_en;
      end
    end
  end

  // A new underrun wins over a clear arriving in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  underrun <= 1'b0;
    else if (w_tick && w_ur_set) underrun <= 1'b1;
    else if (underrun_clr)      underrun <= 1'b0;
  end

endmodule
